fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter PC_WIDTH, default 8, program-counter and instruction-memory address width in bits.
REQ-002 Parameter INSTR_WIDTH, default 32, instruction word width in bits.
REQ-003 Parameter QUEUE_DEPTH, default 4, fetch-queue entry count; power of two, at least 2.
REQ-004 Parameter RESET_PC, default 0, PC value loaded on reset.
REQ-005 Port clk  input  1  single clock; all state updates on rising edge.
REQ-006 Port reset_n  input  1  asynchronous, active-low reset.
REQ-007 Port stall  input  1  high inhibits new fetches; queue still drains.
REQ-008 Port redirect_valid  input  1  high requests flush and PC redirect this cycle.
REQ-009 Port redirect_pc  input  PC_WIDTH  new fetch PC when redirect_valid is high.
REQ-010 Port imem_addr  output  PC_WIDTH  instruction memory address; combinational read.
REQ-011 Port imem_data  input  INSTR_WIDTH  instruction at imem_addr, same cycle.
REQ-012 Port out_valid  output  1  head entry present for the consumer.
REQ-013 Port out_ready  input  1  consumer accepts head entry.
REQ-014 Port out_instr  output  INSTR_WIDTH  head entry instruction.
REQ-015 Port out_pc  output  PC_WIDTH  head entry PC.
REQ-016 Port count  output  clog2(QUEUE_DEPTH)+1  current queue occupancy.

Function
REQ-017 imem_addr SHALL equal the PC register combinationally at all times.
REQ-018 pop SHALL be out_valid AND out_ready; out_valid SHALL be (count != 0) AND NOT redirect_valid.
REQ-019 push SHALL be NOT redirect_valid AND NOT stall AND (count < QUEUE_DEPTH OR pop).
REQ-020 On push, the tail entry SHALL capture {PC, imem_data}, and PC SHALL become PC+1 modulo 2^PC_WIDTH (PC of all ones wraps to 0).
REQ-021 Without push and without redirect, PC SHALL hold.
REQ-022 out_instr/out_pc SHALL reflect the head entry combinationally; values undefined-but-stable when count is 0.
REQ-023 Entries SHALL leave in push order; head/tail pointers wrap modulo QUEUE_DEPTH.
REQ-024 Push and pop in the same cycle SHALL leave count unchanged, including when full (full queue with pop accepts a new entry).
REQ-025 Full queue without pop SHALL not push; PC SHALL hold, so no instruction is skipped.
REQ-026 redirect_valid SHALL take priority over everything: next cycle count=0, pointers reset, PC=redirect_pc; no push, no pop that cycle.
REQ-027 stall SHALL not affect pops, and stall together with redirect_valid SHALL still redirect.
REQ-028 Fetch latency: instruction at PC X pushed in cycle N SHALL be visible at out_* in cycle N+1 at the earliest.

Reset
REQ-029 While reset_n is low: PC=RESET_PC, count=0, head=tail=0, out_valid=0, imem_addr=RESET_PC.
REQ-030 Reset assertion mid-operation SHALL discard all queued entries immediately (asynchronous).
REQ-031 First push SHALL occur on the first rising edge after reset_n deassertion with stall low.
REQ-032 Queue storage contents need not be reset.

Structure
REQ-033 Shared package: default PC_WIDTH, INSTR_WIDTH constants and the fetch-entry record {pc, instr}.
REQ-034 Queue SHALL be a sub-module fetch_queue (parametrised synchronous FIFO with flush, push/pop, count); fetch_unit holds PC and control.
REQ-035 Instruction memory stays external; fetch_unit drives only imem_addr.

Verification
REQ-036 Reset, stall=0, out_ready=1, imem_data=0x1000_0000+addr -> out_pc 0,1,2,... one per cycle from cycle 1, out_instr=0x1000_0000+out_pc.
REQ-037 out_ready=0 for 6 cycles, DEPTH=4 -> count saturates at 4, imem_addr holds at 4; raise out_ready -> out_pc 0,1,2,3,4 without gap or skip.
REQ-038 Queue holds 3 entries, redirect_valid=1 with redirect_pc=0x40 -> next cycle count=0, out_valid=0; following cycle out_pc=0x40.
REQ-039 PC at 0xFE, PC_WIDTH=8, free run -> out_pc sequence 0xFE, 0xFF, 0x00, 0x01.
REQ-040 Full queue, stall=0, out_ready=1 for one cycle -> count stays 4, head advances by one, PC advances by one.
REQ-041 reset_n pulsed low mid-run with count=3 -> out_valid=0 and count=0 immediately, PC=RESET_PC; refetch from RESET_PC after release.

Source files
------------

// File: rtl/fetch_unit_pkg.sv
// Shared fetch-path constants and the fetch-entry record.
// Both the fetch unit and its queue import this package.
package fetch_unit_pkg;

  localparam int DEF_PC_WIDTH    = 8;
  localparam int DEF_INSTR_WIDTH = 32;

  typedef struct packed {
    logic [DEF_PC_WIDTH-1:0]    pc;
    logic [DEF_INSTR_WIDTH-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Synchronous FIFO with flush, simultaneous push/pop and an occupancy count.
// Flush wins over push/pop. Storage is not reset; only the pointers and count are.
module fetch_queue
  import fetch_unit_pkg::*;
#(
  parameter int DATA_W = DEF_PC_WIDTH + DEF_INSTR_WIDTH,
  parameter int DEPTH  = 4
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   flush,
  input  logic                   push,
  input  logic                   pop,
  input  logic [DATA_W-1:0]      wdata,
  output logic [DATA_W-1:0]      rdata,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  head, tail;

  // Power-of-two depth lets the pointers wrap by natural overflow.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) tail <= tail + PTR_W'(1);
      if (pop)  head <= head + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push && !flush) mem[tail] <= wdata;
  end

  assign rdata = mem[head];

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch front end: owns the PC, reads external imem combinationally
// and buffers {pc, instr} pairs in a small queue for the decode stage.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int                   PC_WIDTH    = DEF_PC_WIDTH,
  parameter int                   INSTR_WIDTH = DEF_INSTR_WIDTH,
  parameter int                   QUEUE_DEPTH = 4,
  parameter logic [PC_WIDTH-1:0]  RESET_PC    = '0
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         stall,
  input  logic                         redirect_valid,
  input  logic [PC_WIDTH-1:0]          redirect_pc,
  output logic [PC_WIDTH-1:0]          imem_addr,
  input  logic [INSTR_WIDTH-1:0]       imem_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [INSTR_WIDTH-1:0]       out_instr,
  output logic [PC_WIDTH-1:0]          out_pc,
  output logic [$clog2(QUEUE_DEPTH):0] count
);

  localparam int CNT_W = $clog2(QUEUE_DEPTH) + 1;
  localparam logic [CNT_W-1:0] FULL = CNT_W'(QUEUE_DEPTH);

  typedef struct packed {
    logic [PC_WIDTH-1:0]    pc;
    logic [INSTR_WIDTH-1:0] instr;
  } entry_t;

  logic [PC_WIDTH-1:0] pc;
  logic                push, pop;
  entry_t              wr_entry, head_entry;

  // Redirect blanks the head so a stale entry is never consumed in the flush cycle.
  assign out_valid = (count != '0) && !redirect_valid;
  assign pop       = out_valid && out_ready;
  // A pop frees a slot this cycle, so a full queue can still accept a fetch.
  assign push      = !redirect_valid && !stall && ((count < FULL) || pop);

  assign imem_addr = pc;
  assign wr_entry  = '{pc: pc, instr: imem_data};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)            pc <= RESET_PC;
    else if (redirect_valid) pc <= redirect_pc;
    else if (push)           pc <= pc + PC_WIDTH'(1);
  end

  fetch_queue #(
    .DATA_W (PC_WIDTH + INSTR_WIDTH),
    .DEPTH  (QUEUE_DEPTH)
  ) u_queue (
    .clk     (clk),
    .reset_n (reset_n),
    .flush   (redirect_valid),
    .push    (push),
    .pop     (pop),
    .wdata   (wr_entry),
    .rdata   (head_entry),
    .count   (count)
  );

  assign out_pc    = head_entry.pc;
  assign out_instr = head_entry.instr;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios with literal expectations
// plus a randomized run checked every cycle against a queue-based model.
module tb_fetch_unit;
  import fetch_unit_pkg::*;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        stall, redirect_valid, out_ready;
  logic [7:0]  redirect_pc;
  logic [7:0]  imem_addr;
  logic [31:0] imem_data;
  logic        out_valid;
  logic [31:0] out_instr;
  logic [7:0]  out_pc;
  logic [2:0]  count;

  int n_tests = 0;
  int n_fail  = 0;

  fetch_unit #(.PC_WIDTH(8), .INSTR_WIDTH(32), .QUEUE_DEPTH(DEPTH), .RESET_PC(8'h00)) dut (
    .clk(clk), .reset_n(reset_n), .stall(stall), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .imem_addr(imem_addr), .imem_data(imem_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
    .out_pc(out_pc), .count(count)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(logic [7:0] a);
    return 32'h1000_0000 + 32'(a);
  endfunction

  assign imem_data = mem_word(imem_addr);

  function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endfunction

  // Reference model: a plain queue of fetched entries and a PC.
  fetch_entry_t mq[$];
  logic [7:0]   mpc = 8'h00;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mq.delete();
      mpc = 8'h00;
    end else if (redirect_valid) begin
      mq.delete();
      mpc = redirect_pc;
    end else begin
      int  sz;
      bit  pop_m, push_m;
      sz     = mq.size();
      pop_m  = (sz != 0) && out_ready;
      push_m = !stall && (sz < DEPTH || pop_m);
      if (pop_m) void'(mq.pop_front());
      if (push_m) begin
        mq.push_back('{pc: mpc, instr: mem_word(mpc)});
        mpc = mpc + 8'd1;
      end
    end
  end

  always @(negedge clk) begin
    #1;
    chk("model_count", 64'(count), 64'(mq.size()));
    chk("model_imem_addr", 64'(imem_addr), 64'(mpc));
    chk("model_out_valid", 64'(out_valid), 64'((mq.size() != 0) && !redirect_valid));
    if (mq.size() != 0 && !redirect_valid) begin
      chk("model_out_pc", 64'(out_pc), 64'(mq[0].pc));
      chk("model_out_instr", 64'(out_instr), 64'(mq[0].instr));
    end
  end

  logic [7:0] exp_wrap [4];

  initial begin
    exp_wrap = '{8'hFE, 8'hFF, 8'h00, 8'h01};
    reset_n = 1'b0; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = '0; out_ready = 1'b1;

    // Reset state
    repeat (2) @(negedge clk);
    #2;
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_imem_addr", 64'(imem_addr), 64'd0);
    @(negedge clk) reset_n = 1'b1;

    // Free run: one instruction per cycle starting at PC 0
    for (int k = 0; k < 6; k++) begin
      @(negedge clk); #2;
      chk("run_pc", 64'(out_pc), 64'(k));
      chk("run_instr", 64'(out_instr), 64'(32'h1000_0000 + k));
    end

    // Back-pressure: queue saturates, PC holds, then drains without gaps
    out_ready = 1'b0;
    @(negedge clk); #3 reset_n = 1'b0;
    @(negedge clk) reset_n = 1'b1;
    repeat (6) @(negedge clk);
    out_ready = 1'b1;
    #2;
    chk("sat_count", 64'(count), 64'd4);
    chk("sat_imem_addr", 64'(imem_addr), 64'd4);
    chk("drain_pc0", 64'(out_pc), 64'd0);
    @(negedge clk); #2;
    chk("full_pop_count", 64'(count), 64'd4);
    chk("full_pop_pc", 64'(out_pc), 64'd1);
    chk("full_pop_imem_addr", 64'(imem_addr), 64'd5);
    for (int k = 2; k < 5; k++) begin
      @(negedge clk); #2;
      chk("drain_pc", 64'(out_pc), 64'(k));
    end

    // Redirect with three entries queued
    @(negedge clk); redirect_valid = 1'b1; redirect_pc = 8'h10; out_ready = 1'b0;
    @(negedge clk); redirect_valid = 1'b0;
    repeat (3) @(negedge clk);
    #2;
    chk("pre_redir_count", 64'(count), 64'd3);
    redirect_valid = 1'b1; redirect_pc = 8'h40;
    #1;
    chk("redir_valid_blank", 64'(out_valid), 64'd0);
    @(negedge clk); redirect_valid = 1'b0;
    #2;
    chk("post_redir_count", 64'(count), 64'd0);
    chk("post_redir_valid", 64'(out_valid), 64'd0);
    @(negedge clk); #2;
    chk("redir_target_pc", 64'(out_pc), 64'h40);
    chk("redir_target_valid", 64'(out_valid), 64'd1);

    // PC wrap at 8 bits
    @(negedge clk); redirect_valid = 1'b1; redirect_pc = 8'hFE; out_ready = 1'b1;
    @(negedge clk); redirect_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk); #2;
      chk("wrap_pc", 64'(out_pc), 64'(exp_wrap[k]));
    end

    // Asynchronous reset mid-run with three entries queued
    @(negedge clk); redirect_valid = 1'b1; redirect_pc = 8'h20; out_ready = 1'b0;
    @(negedge clk); redirect_valid = 1'b0;
    repeat (3) @(negedge clk);
    #2;
    chk("pre_rst_count", 64'(count), 64'd3);
    #1 reset_n = 1'b0;
    #1;
    chk("async_rst_valid", 64'(out_valid), 64'd0);
    chk("async_rst_count", 64'(count), 64'd0);
    chk("async_rst_imem_addr", 64'(imem_addr), 64'd0);
    @(negedge clk); reset_n = 1'b1; out_ready = 1'b1;
    @(negedge clk); #2;
    chk("refetch_pc", 64'(out_pc), 64'd0);
    chk("refetch_valid", 64'(out_valid), 64'd1);

    // Randomized traffic checked by the model every cycle
    for (int i = 0; i < 800; i++) begin
      @(negedge clk);
      stall          = ($urandom_range(0, 9) < 3);
      redirect_valid = ($urandom_range(0, 99) < 7);
      redirect_pc    = 8'($urandom);
      out_ready      = ($urandom_range(0, 9) < 6);
    end
    @(negedge clk);
    redirect_valid = 1'b0; stall = 1'b0;
    repeat (3) @(negedge clk);
    #3;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
